// File: rtl/shared_counter_arbiter_if.sv
// Bus between two counter requesters and the shared counter arbiter.
// slave: the arbiter side; master: the requester/bench side.
interface shared_counter_arbiter_if #(
   parameter int unsigned WIDTH = 8
);
   logic             req0_valid;
   logic             req1_valid;
   logic [1:0]       req0_op;
   logic [1:0]       req1_op;
   logic [WIDTH-1:0] req0_data;
   logic [WIDTH-1:0] req1_data;
   logic             req0_lock;
   logic             req1_lock;
   logic             req0_ready;
   logic             req1_ready;
   logic             rsp_valid;
   logic             rsp_id;
   logic [WIDTH-1:0] rsp_data;
   logic [WIDTH-1:0] count;
   logic             wrapped;
   logic             wrap_clr;

   modport slave (
      input  req0_valid, req1_valid, req0_op, req1_op, req0_data, req1_data,
      input  req0_lock, req1_lock, wrap_clr,
      output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, count, wrapped
   );

   modport master (
      output req0_valid, req1_valid, req0_op, req1_op, req0_data, req1_data,
      output req0_lock, req1_lock, wrap_clr,
      input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, count, wrapped
   );
endinterface

// File: rtl/shared_counter_arbiter.sv
// Two-requester arbiter in front of one shared up/down/load counter.
// Round-robin when idle; a requester can lock ownership for up to MAX_HOLD grants.
module shared_counter_arbiter #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned MAX_HOLD = 4   // legal range 1..15
) (
   input  logic                    clk,
   input  logic                    rst_n,
   shared_counter_arbiter_if.slave bus
);

   localparam int unsigned HOLD_W = 4;
   localparam logic [1:0]  OP_INC = 2'b00;
   localparam logic [1:0]  OP_DEC = 2'b01;
   localparam logic [1:0]  OP_LD  = 2'b10;
   localparam logic [1:0]  OP_CLR = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN0 = 2'd1,
      ST_OWN1 = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_arm;
   logic                r_rr_ptr;
   logic                w_rr_ptr_nxt;
   logic [HOLD_W-1:0]   r_hold;
   logic [HOLD_W-1:0]   w_hold_nxt;
   logic [HOLD_W-1:0]   w_hold_inc;
   logic [WIDTH-1:0]    r_count;
   logic [WIDTH-1:0]    w_count_nxt;
   logic                r_wrapped;
   logic                w_wrapped_nxt;
   logic                w_wrap;
   logic                r_rsp_valid;
   logic                r_rsp_id;
   logic [WIDTH-1:0]    r_rsp_data;
   logic                w_gnt0;
   logic                w_gnt1;
   logic                w_accept;
   logic                w_sel;
   logic                w_lock;
   logic                w_release;
   logic [1:0]          w_op;
   logic [WIDTH-1:0]    w_data;

   // Operand mux follows the granted requester
   assign w_accept   = w_gnt0 | w_gnt1;
   assign w_sel      = w_gnt1;
   assign w_op       = w_sel ? bus.req1_op   : bus.req0_op;
   assign w_data     = w_sel ? bus.req1_data : bus.req0_data;
   assign w_lock     = w_sel ? bus.req1_lock : bus.req0_lock;
   assign w_hold_inc = r_hold + HOLD_W'(1);

   // Grant, ownership and round-robin next state
   always_comb begin
      w_gnt0       = 1'b0;
      w_gnt1       = 1'b0;
      w_release    = 1'b0;
      w_state_nxt  = r_state;
      w_rr_ptr_nxt = r_rr_ptr;
      w_hold_nxt   = r_hold;

      if (r_arm) begin
         unique case (r_state)
            ST_IDLE: begin
               if (bus.req0_valid && bus.req1_valid) begin
                  w_gnt0 = ~r_rr_ptr;
                  w_gnt1 = r_rr_ptr;
               end else begin
                  w_gnt0 = bus.req0_valid;
                  w_gnt1 = bus.req1_valid;
               end
            end
            ST_OWN0: w_gnt0 = bus.req0_valid;
            ST_OWN1: w_gnt1 = bus.req1_valid;
            default: ;
         endcase
      end

      unique case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_rr_ptr_nxt = ~w_sel;
               if (w_lock && (MAX_HOLD > 1)) begin
                  w_state_nxt = w_sel ? ST_OWN1 : ST_OWN0;
                  w_hold_nxt  = HOLD_W'(1);
               end
            end
         end
         ST_OWN0, ST_OWN1: begin
            // Owner went idle, unlocked, or used up its hold budget
            if (!w_accept || !w_lock) begin
               w_release = 1'b1;
            end else if (w_hold_inc >= HOLD_W'(MAX_HOLD)) begin
               w_release = 1'b1;
            end else begin
               w_hold_nxt = w_hold_inc;
            end
            if (w_release) begin
               w_state_nxt  = ST_IDLE;
               w_rr_ptr_nxt = (r_state == ST_OWN0);
               w_hold_nxt   = '0;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_hold_nxt  = '0;
         end
      endcase
   end

   // Counter datapath and wrap detection
   always_comb begin
      w_count_nxt = r_count;
      w_wrap      = 1'b0;
      if (w_accept) begin
         unique case (w_op)
            OP_INC: begin
               w_count_nxt = r_count + WIDTH'(1);
               w_wrap      = &r_count;
            end
            OP_DEC: begin
               w_count_nxt = r_count - WIDTH'(1);
               w_wrap      = ~|r_count;
            end
            OP_LD:   w_count_nxt = w_data;
            OP_CLR:  w_count_nxt = '0;
            default: ;
         endcase
      end
      w_wrapped_nxt = w_wrap | (r_wrapped & ~bus.wrap_clr);
   end

   // r_arm keeps the first edge after reset release free of accepts
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_arm       <= 1'b0;
         r_rr_ptr    <= 1'b0;
         r_hold      <= '0;
         r_count     <= '0;
         r_wrapped   <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_id    <= 1'b0;
         r_rsp_data  <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_arm       <= 1'b1;
         r_rr_ptr    <= w_rr_ptr_nxt;
         r_hold      <= w_hold_nxt;
         r_count     <= w_count_nxt;
         r_wrapped   <= w_wrapped_nxt;
         r_rsp_valid <= w_accept;
         if (w_accept) begin
            r_rsp_id   <= w_sel;
            r_rsp_data <= w_count_nxt;
         end
      end
   end

   assign bus.req0_ready = w_gnt0;
   assign bus.req1_ready = w_gnt1;
   assign bus.rsp_valid  = r_rsp_valid;
   assign bus.rsp_id     = r_rsp_id;
   assign bus.rsp_data   = r_rsp_data;
   assign bus.count      = r_count;
   assign bus.wrapped    = r_wrapped;

endmodule

// File: tb/tb_shared_counter_arbiter.sv
// Scoreboard bench: a queue/integer model predicts grants and responses,
// a negedge monitor pops expectations whenever a response is due.
module tb_shared_counter_arbiter;
   localparam int unsigned WIDTH    = 8;
   localparam int unsigned MAX_HOLD = 4;

   logic clk = 1'b0;
   logic rst_n;

   shared_counter_arbiter_if #(.WIDTH(WIDTH)) bus ();
   shared_counter_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       id;
      logic [7:0] data;
   } rsp_t;

   rsp_t exp_q[$];
   rsp_t obs_q[$];
   int   errors = 0;
   int   checks = 0;

   // Reference model state: owner -1 means nobody holds the counter
   int   m_owner, m_hold, m_ptr, m_count, m_last_id, m_last_data;
   bit   m_wrapped, m_armed;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_owner = -1; m_hold = 0; m_ptr = 0; m_count = 0;
      m_last_id = 0; m_last_data = 0; m_wrapped = 0; m_armed = 0;
      exp_q.delete();
   endtask

   function automatic int pick();
      bit v0 = bus.req0_valid;
      bit v1 = bus.req1_valid;
      if (!m_armed) return -1;
      if (m_owner == 0) return v0 ? 0 : -1;
      if (m_owner == 1) return v1 ? 1 : -1;
      if (v0 && v1) return m_ptr;
      if (v0) return 0;
      if (v1) return 1;
      return -1;
   endfunction

   task automatic model_step(input int g);
      int   op, d;
      bit   lk, wrap;
      rsp_t r;
      if (g < 0) begin
         m_wrapped = m_wrapped && !bus.wrap_clr;
         if (m_owner >= 0) begin
            m_ptr   = 1 - m_owner;
            m_owner = -1;
         end
         return;
      end
      op   = (g == 1) ? int'(bus.req1_op)   : int'(bus.req0_op);
      d    = (g == 1) ? int'(bus.req1_data) : int'(bus.req0_data);
      lk   = (g == 1) ? bus.req1_lock       : bus.req0_lock;
      wrap = 0;
      case (op)
         0: begin wrap = (m_count == 255); m_count = (m_count + 1) % 256; end
         1: begin wrap = (m_count == 0);   m_count = (m_count + 255) % 256; end
         2: m_count = d;
         default: m_count = 0;
      endcase
      r.id   = g[0];
      r.data = m_count[7:0];
      exp_q.push_back(r);
      m_wrapped = wrap || (m_wrapped && !bus.wrap_clr);
      if (m_owner < 0) begin
         m_ptr = 1 - g;
         if (lk && MAX_HOLD > 1) begin
            m_owner = g;
            m_hold  = 1;
         end
      end else begin
         if (lk) m_hold++;
         if (!lk || m_hold >= MAX_HOLD) begin
            m_owner = -1;
            m_ptr   = 1 - g;
         end
      end
   endtask

   // Monitor first (responses from the previous edge), then predict this cycle
   always @(negedge clk) begin
      rsp_t e;
      int   g;
      if (!rst_n) begin
         model_reset();
         check("rst_ready0", bus.req0_ready, 0);
         check("rst_ready1", bus.req1_ready, 0);
      end else begin
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rsp_valid", bus.rsp_valid, 1);
            check("rsp_id", bus.rsp_id, e.id);
            check("rsp_data", bus.rsp_data, e.data);
            obs_q.push_back(rsp_t'({bus.rsp_id, bus.rsp_data}));
            m_last_id   = int'(e.id);
            m_last_data = int'(e.data);
         end else begin
            check("rsp_idle", bus.rsp_valid, 0);
            check("rsp_hold_id", bus.rsp_id, m_last_id);
            check("rsp_hold_data", bus.rsp_data, m_last_data);
         end
         check("count", bus.count, m_count);
         check("wrapped", bus.wrapped, m_wrapped);
         g = pick();
         check("ready0", bus.req0_ready, g == 0);
         check("ready1", bus.req1_ready, g == 1);
         model_step(g);
         m_armed = 1;
      end
   end

   task automatic drive(input bit v0, input bit [1:0] o0, input logic [7:0] d0, input bit l0,
                        input bit v1, input bit [1:0] o1, input logic [7:0] d1, input bit l1,
                        input bit clr);
      bus.req0_valid = v0; bus.req0_op = o0; bus.req0_data = d0; bus.req0_lock = l0;
      bus.req1_valid = v1; bus.req1_op = o1; bus.req1_data = d1; bus.req1_lock = l1;
      bus.wrap_clr   = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      rst_n = 1'b0;
      bus.req0_valid = 0; bus.req0_op = 0; bus.req0_data = 0; bus.req0_lock = 0;
      bus.req1_valid = 0; bus.req1_op = 0; bus.req1_data = 0; bus.req1_lock = 0;
      bus.wrap_clr   = 0;
      model_reset();
      #2;
      check("reset_count", bus.count, 0);
      check("reset_wrapped", bus.wrapped, 0);
      check("reset_rsp_valid", bus.rsp_valid, 0);
      check("reset_rsp_data", bus.rsp_data, 0);
      @(posedge clk); #1;
      @(posedge clk); #1;

      // Round-robin; the first edge after release must not accept
      rst_n = 1'b1;
      obs_q.delete();
      repeat (5) drive(1, 0, 0, 0, 1, 0, 0, 0, 0);
      idle();
      check("arb_n", obs_q.size(), 4);
      if (obs_q.size() == 4)
         for (int i = 0; i < 4; i++) begin
            check("arb_id", obs_q[i].id, i % 2);
            check("arb_data", obs_q[i].data, i + 1);
         end

      // Lock limit: req0 keeps 4 grants, then req1
      obs_q.delete();
      drive(0, 0, 0, 0, 1, 3, 0, 0, 0);
      repeat (5) drive(1, 0, 0, 1, 1, 0, 0, 0, 0);
      idle();
      check("lock_count", bus.count, 5);
      check("lock_n", obs_q.size(), 6);
      if (obs_q.size() == 6)
         for (int i = 1; i < 6; i++) check("lock_id", obs_q[i].id, (i == 5) ? 1 : 0);

      // Wraps and clear priority
      obs_q.delete();
      drive(1, 2, 8'hFF, 0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
      idle();
      check("wrap_inc_flag", bus.wrapped, 1);
      check("wrap_inc_data", bus.rsp_data, 8'h00);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
      check("wrap_clr", bus.wrapped, 0);
      drive(1, 2, 8'h00, 0, 0, 0, 0, 0, 0);
      drive(1, 1, 0, 0, 0, 0, 0, 0, 1);
      idle();
      check("wrap_dec_data", bus.rsp_data, 8'hFF);
      check("wrap_set_wins", bus.wrapped, 1);

      // Early release: owner req1 goes idle, req0 waits then wins
      obs_q.delete();
      drive(0, 0, 0, 0, 1, 0, 0, 1, 0);
      bus.req0_valid = 1; bus.req0_op = 0; bus.req0_lock = 0;
      bus.req1_valid = 0;
      #1;
      check("own_blocks_other", bus.req0_ready, 0);
      @(posedge clk); #1;
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 1, 0, 0, 0, 0);
      idle();
      check("early_n", obs_q.size(), 3);
      if (obs_q.size() == 3) begin
         check("early_id0", obs_q[0].id, 1);
         check("early_id1", obs_q[1].id, 0);
         check("early_ptr", obs_q[2].id, 1);
      end

      // Reset pulse between edges while req0 owns the counter
      drive(1, 2, 8'h37, 1, 0, 0, 0, 0, 0);
      check("pre_rst_count", bus.count, 8'h37);
      bus.req0_op = 0;
      rst_n = 1'b0;
      #1;
      check("rst_mid_count", bus.count, 0);
      check("rst_mid_rsp_valid", bus.rsp_valid, 0);
      check("rst_mid_rsp_data", bus.rsp_data, 0);
      check("rst_mid_rsp_id", bus.rsp_id, 0);
      check("rst_mid_wrapped", bus.wrapped, 0);
      check("rst_mid_ready0", bus.req0_ready, 0);
      model_reset();
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_no_accept", bus.count, 0);
      drive(1, 0, 0, 1, 0, 0, 0, 0, 0);
      idle();
      check("post_rst_count", bus.count, 1);

      // Randomized traffic against the model
      for (int n = 0; n < 600; n++) begin
         bit [1:0]   o0, o1;
         logic [7:0] d0, d1;
         int         k;
         k  = int'($urandom_range(0, 9));
         o0 = (k < 4) ? 2'd0 : (k < 7) ? 2'd1 : (k < 9) ? 2'd2 : 2'd3;
         k  = int'($urandom_range(0, 9));
         o1 = (k < 4) ? 2'd0 : (k < 7) ? 2'd1 : (k < 9) ? 2'd2 : 2'd3;
         d0 = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
         d1 = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
         drive($urandom_range(0, 3) != 0, o0, d0, 1'($urandom),
               $urandom_range(0, 3) != 0, o1, d1, 1'($urandom),
               $urandom_range(0, 7) == 0);
      end
      idle();
      idle();
      check("drain", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
